// File: rtl/iana_stream_packer.sv
// Record FIFO + serializer: 128-bit trace records out as four 32-bit AXI-Stream beats,
// framed into packets of PKT_RECORDS records. Optional packet header: `define IANA_PACK_SEQ_EN.
module iana_stream_packer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PKT_RECORDS = 64,
  parameter logic [31:0] PAD_WORD    = 32'hFFFF_FFFF
) (
  input  logic                   pl_clk,
  input  logic                   nreset,
  input  logic                   enable,
  input  logic [127:0]           rec_in,
  input  logic                   rec_we,
  input  logic                   flush,
  output logic [31:0]            m_tdata,
  output logic [3:0]             m_tkeep,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   overflow,
  output logic [15:0]            drop_count,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam int unsigned    LW       = AW + 1;
  localparam logic [LW-1:0]  FULL_LVL = LW'(DEPTH);
  localparam logic [15:0]    LAST_IDX = 16'(PKT_RECORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_PAD, S_HDR} state_t;

  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [LW-1:0] level_q, level_d;
  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [31:0]   tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;
  logic [15:0]   pkt_q, pkt_d;
  logic          fp_q, fp_d;
`ifdef IANA_PACK_SEQ_EN
  logic [15:0]   seq_q, seq_d;
`endif

  logic          push, drop, fire, pop, tlast_done, load;
  logic [127:0]  head, nxt_rec, load_rec;

  // The record being sent stays in the FIFO until its last beat, so level/full include it.
  assign push       = rec_we & enable & (level_q != FULL_LVL);
  assign drop       = rec_we & enable & (level_q == FULL_LVL);
  assign fire       = tvalid_q & m_tready;
  assign pop        = fire & (state_q == S_SEND) & (beat_q == 2'd3);
  assign tlast_done = fire & tlast_q;
  assign rd_nxt     = rd_ptr_q + AW'(1);
  assign head       = mem_q[rd_ptr_q];
  assign nxt_rec    = mem_q[rd_nxt];

  always_ff @(posedge pl_clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_in;
  end

  always_comb begin
    level_d = level_q + LW'(push) - LW'(pop);
    ovf_d   = ovf_q | drop;
    drop_d  = (drop && (drop_q != '1)) ? drop_q + 16'd1 : drop_q;
    pkt_d   = tlast_done ? '0 : (pop ? pkt_q + 16'd1 : pkt_q);
    fp_d    = fp_q & ~tlast_done;
    // A flush with nothing sent and nothing queued (counting a coincident push) is dropped.
    if (flush && ((pkt_d != '0) || (level_d != '0))) fp_d = 1'b1;
`ifdef IANA_PACK_SEQ_EN
    seq_d   = tlast_done ? seq_q + 16'd1 : seq_q;
`endif

    state_d  = state_q;
    beat_d   = beat_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    load     = 1'b0;
    load_rec = head;

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          load = 1'b1;
        end else if (fp_q && (pkt_q != '0)) begin
          state_d  = S_PAD;
          beat_d   = '0;
          tdata_d  = PAD_WORD;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
        end
      end
      S_SEND, S_PAD: begin
        if (fire) begin
          if (beat_q != 2'd3) begin
            beat_d  = beat_q + 2'd1;
            tdata_d = (state_q == S_PAD) ? PAD_WORD : head[{beat_d, 5'd0} +: 32];
            // tlast for beat 3 is decided as beat 2 retires, using post-cycle occupancy.
            tlast_d = (beat_q == 2'd2) &&
                      ((state_q == S_PAD) || (pkt_q == LAST_IDX) ||
                       (fp_d && (level_d <= LW'(1))));
          end else if ((state_q == S_SEND) && (level_q > LW'(1))) begin
            load     = 1'b1;
            load_rec = nxt_rec;
          end else begin
            state_d  = S_IDLE;
            beat_d   = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
        end
      end
      S_HDR: begin
        if (fire) begin
          state_d = S_SEND;
          beat_d  = '0;
          tdata_d = head[31:0];
          tlast_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      beat_d   = '0;
      tvalid_d = 1'b1;
      tlast_d  = 1'b0;
`ifdef IANA_PACK_SEQ_EN
      if (pkt_d == '0) begin
        state_d = S_HDR;
        tdata_d = {16'hA5A5, seq_d};
      end else
`endif
      begin
        state_d = S_SEND;
        tdata_d = load_rec[31:0];
      end
    end
  end

  always_ff @(posedge pl_clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      pkt_q    <= '0;
      fp_q     <= 1'b0;
`ifdef IANA_PACK_SEQ_EN
      seq_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      pkt_q    <= pkt_d;
      fp_q     <= fp_d;
`ifdef IANA_PACK_SEQ_EN
      seq_q    <= seq_d;
`endif
    end
  end

  assign m_tdata    = tdata_q;
  assign m_tkeep    = 4'hF;
  assign m_tlast    = tlast_q;
  assign m_tvalid   = tvalid_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign level      = level_q;

endmodule

// File: tb/tb_iana_stream_packer.sv
// Directed + random bench for iana_stream_packer: expected beat stream built from accepted records.
`timescale 1ns/1ps
module tb_iana_stream_packer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PKT   = 2;
  localparam logic [31:0] PADW  = 32'hFFFF_FFFF;

  logic         pl_clk = 1'b0;
  logic         nreset, enable, rec_we, flush, m_tready;
  logic [127:0] rec_in;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic         m_tlast, m_tvalid, overflow;
  logic [15:0]  drop_count;
  logic [4:0]   level;

  int unsigned errs = 0, checks = 0;
  logic [33:0] exp_q[$];   // {record_end, tlast, data}
  int unsigned n_acc = 0, n_done = 0, n_beats = 0, m_pkt = 0, m_drops = 0;
  logic        m_ovf = 1'b0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_beat = '0;

  iana_stream_packer #(.DEPTH(DEPTH), .PKT_RECORDS(PKT), .PAD_WORD(PADW)) dut (
    .pl_clk(pl_clk), .nreset(nreset), .enable(enable), .rec_in(rec_in), .rec_we(rec_we),
    .flush(flush), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .overflow(overflow),
    .drop_count(drop_count), .level(level)
  );

  always #5 pl_clk = ~pl_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_push(input logic [127:0] r, input logic fl);
    logic tl;
    tl = (m_pkt == PKT - 1) || fl;
    for (int unsigned k = 0; k < 4; k++)
      exp_q.push_back({k == 3, (k == 3) && tl, r[32*k +: 32]});
    m_pkt = tl ? 0 : m_pkt + 1;
  endtask

  task automatic model_pad();
    for (int unsigned k = 0; k < 4; k++) exp_q.push_back({1'b0, k == 3, PADW});
    m_pkt = 0;
  endtask

  task automatic sync();
    @(posedge pl_clk); #1;
  endtask

  // Drives one clock's worth of inputs (called at posedge+1) and updates the model.
  task automatic cycle(input logic we, input logic [127:0] r, input logic en,
                       input logic fl, input logic rdy);
    logic accepted;
    accepted = 1'b0;
    rec_we = we; rec_in = r; enable = en; flush = fl; m_tready = rdy;
    if (we && en) begin
      if (n_acc - n_done == DEPTH) begin
        m_ovf = 1'b1;
        if (m_drops != 65535) m_drops++;
      end else begin
        n_acc++;
        accepted = 1'b1;
        model_push(r, fl);
      end
    end
    if (fl && !accepted && m_pkt != 0) model_pad();
    sync();
    rec_we = 1'b0; flush = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge pl_clk);
      if (exp_q.size() == 0 && !m_tvalid) ok = 1'b1;
    end
    chk(tag, ok, 1);
    sync();
  endtask

  always @(negedge pl_clk) begin : mon
    logic [33:0] e;
    if (!nreset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_beat", {m_tlast, m_tdata}, prev_beat);
      end
      if (m_tvalid && m_tready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", m_tvalid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {m_tlast, m_tdata}, e[32:0]);
          if (e[33]) n_done++;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b0;
    nreset = 1'b0; enable = 1'b0; rec_we = 1'b0; flush = 1'b0; m_tready = 1'b0; rec_in = '0;
    repeat (2) @(posedge pl_clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", m_tkeep, 4'hF);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_level", level, 0);
    nreset = 1'b1; enable = 1'b1;
    sync();

    // Single record: one cycle of latency, then four consecutive beats, no tlast.
    cycle(1, 128'h00000003_00000002_00000001_00000000, 1, 0, 1);
    @(negedge pl_clk);
    chk("t1_latency", m_tvalid, 0);
    chk("t1_level", level, 1);
    repeat (4) begin @(negedge pl_clk); chk("t1_consec", m_tvalid, 1); end
    @(negedge pl_clk);
    chk("t1_end", m_tvalid, 0);
    sync();
    drain("t1_drain");
    chk("t1_level0", level, 0);

    // Flush closes the open packet with a pad record; a second flush does nothing.
    cycle(0, '0, 1, 1, 1);
    drain("pad_drain");
    cycle(0, '0, 1, 1, 1);
    repeat (8) begin @(negedge pl_clk); chk("flush_ignored", m_tvalid, 0); end
    sync();

    // Three records back to back: 12 beats, no bubble, tlast on beat 8.
    for (int i = 0; i < 3; i++) cycle(1, rnd(), 1, 0, 1);
    repeat (11) begin @(negedge pl_clk); chk("t2_nobubble", m_tvalid, 1); end
    @(negedge pl_clk);
    chk("t2_idle", m_tvalid, 0);
    chk("t2_level", level, 0);
    sync();
    cycle(0, '0, 1, 1, 1);
    drain("t2_close");

    // Flush coincident with a push on an empty packet: that record carries tlast.
    cycle(1, rnd(), 1, 1, 1);
    drain("coinc_drain");

    // Overflow: 20 pushes while stalled.
    for (int i = 0; i < 20; i++) cycle(1, rnd(), 1, 0, 0);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 4);
    chk("ovf_valid", m_tvalid, 1);
    b0 = n_beats;
    drain("ovf_drain");
    chk("ovf_beats", n_beats - b0, 64);
    chk("ovf_level0", level, 0);

    // Random traffic with a random ready and occasional disable.
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 2)) cycle(0, '0, 1, 0, 1'($urandom_range(0, 1)));
      cycle(1, rnd(), 1'($urandom_range(0, 9) != 0), 0, 1'($urandom_range(0, 1)));
    end
    drain("rand_drain");
    cycle(0, '0, 1, 1, 1);
    drain("rand_close");
    chk("rand_overflow", overflow, m_ovf);
    chk("rand_drops", drop_count, m_drops);
    chk("rand_level", level, 0);

    // Reset while a beat is pending.
    for (int i = 0; i < 18; i++) cycle(1, rnd(), 1, 0, 0);
    chk("pre_rst_valid", m_tvalid, 1);
    chk("pre_rst_ovf", overflow, 1);
    #2 nreset = 1'b0;
    #1;
    chk("mid_rst_valid", m_tvalid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_drop", drop_count, 0);
    exp_q.delete();
    n_acc = 0; n_done = 0; m_pkt = 0; m_drops = 0; m_ovf = 1'b0;
    m_tready = 1'b1;
    #3 nreset = 1'b1;
    repeat (10) begin @(negedge pl_clk); chk("post_rst_quiet", m_tvalid, 0); end
    chk("post_rst_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
